// File: rtl/hoplite_pkg.sv
// -----------------------------------------------------------------------------
// hoplite_pkg
//   Shared definitions for the Hoplite PE-side port: default flit and header
//   widths, the default flit type, and helpers that locate the destination
//   header fields in a flit.
//
//   Header layout, with the destination in the MSBs:
//     dst_x = flit[P_W-1     -: X_W]
//     dst_y = flit[P_W-1-X_W -: Y_W]
// -----------------------------------------------------------------------------
package hoplite_pkg;

    localparam int FLIT_W_DEFAULT  = 32;
    localparam int DST_X_W_DEFAULT = 4;
    localparam int DST_Y_W_DEFAULT = 4;

    typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

    // MSB positions of the header fields. These are constant functions, so a
    // parameterised module can use them to size its own slices.
    function automatic int dst_x_msb(input int p_w);
        return p_w - 1;
    endfunction

    function automatic int dst_y_msb(input int p_w, input int x_w);
        return p_w - 1 - x_w;
    endfunction

    // Field extraction for flits that use the default widths.
    function automatic logic [DST_X_W_DEFAULT-1:0] get_dst_x(input flit_t f);
        return f[dst_x_msb(FLIT_W_DEFAULT) -: DST_X_W_DEFAULT];
    endfunction

    function automatic logic [DST_Y_W_DEFAULT-1:0] get_dst_y(input flit_t f);
        return f[dst_y_msb(FLIT_W_DEFAULT, DST_X_W_DEFAULT) -: DST_Y_W_DEFAULT];
    endfunction

endpackage

// File: rtl/hoplite_inj_fifo.sv
// -----------------------------------------------------------------------------
// hoplite_inj_fifo
//   Synchronous FIFO used on the injection path. Full and empty are registered,
//   so there is no combinational path from pop_req to full.
//
//   Ports:
//     clk, rst      clock; synchronous active-high reset
//     push_valid    write request; ignored while full
//     push_data     data to write
//     pop_req       read request; ignored while empty
//     rd_data       head entry (don't-care while empty)
//     full, empty   registered status flags
//
//   DEPTH must be a power of 2 and at least 2. The pointers carry one extra
//   wrap bit, which tells full apart from empty.
// -----------------------------------------------------------------------------
module hoplite_inj_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // The flags are computed from the next pointers, so the registered flags
    // always agree with the pointers they will sit beside.
    always_comb begin
        do_push  = push_valid && !full_q;
        do_pop   = pop_req && !empty_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Storage is not reset; its contents are unused until a push marks them valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/hoplite_pe_port.sv
// -----------------------------------------------------------------------------
// hoplite_pe_port
//   PE-side endpoint of a Hoplite torus router.
//   Injection path: PE flits are queued in hoplite_inj_fifo. The head flit is
//   offered to the router, which pops it by pulsing noc_inj_ack when it grants
//   injection.
//   Ejection path: flits from the router are registered toward the PE. Their
//   destination header is checked against (X_ID, Y_ID).
//
//   Ports:
//     clk, rst                    clock; synchronous active-high reset
//     pe_in_data/valid/ready      PE -> port injection handshake
//     noc_inj_data/valid, ack     head flit to the router PE input; ack pops it
//     noc_ej_data/valid           flit ejected by the router (no back-pressure)
//     pe_out_data/valid           registered ejected flit, one-cycle pulse
//     err_misroute                sticky flag; cleared only by rst
//
//   Optional build macro HOPLITE_PE_PORT_STATS_EN adds three saturating 32-bit
//   counters: stat_inj_cnt, stat_ej_cnt and stat_stall_cnt.
// -----------------------------------------------------------------------------
module hoplite_pe_port
    import hoplite_pkg::*;
#(
    parameter int P_W        = 32,
    parameter int X_W        = 4,
    parameter int Y_W        = 4,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [P_W-1:0] pe_in_data,
    input  logic           pe_in_valid,
    output logic           pe_in_ready,
    output logic [P_W-1:0] noc_inj_data,
    output logic           noc_inj_valid,
    input  logic           noc_inj_ack,
    input  logic [P_W-1:0] noc_ej_data,
    input  logic           noc_ej_valid,
    output logic [P_W-1:0] pe_out_data,
    output logic           pe_out_valid,
`ifdef HOPLITE_PE_PORT_STATS_EN
    output logic [31:0]    stat_inj_cnt,
    output logic [31:0]    stat_ej_cnt,
    output logic [31:0]    stat_stall_cnt,
`endif
    output logic           err_misroute
);

    localparam int              DX_MSB = dst_x_msb(P_W);
    localparam int              DY_MSB = dst_y_msb(P_W, X_W);
    localparam logic [X_W-1:0]  MY_X   = X_W'(X_ID);
    localparam logic [Y_W-1:0]  MY_Y   = Y_W'(Y_ID);

    logic           fifo_full;
    logic           fifo_empty;
    logic           inj_pop;
    logic [X_W-1:0] ej_dst_x;
    logic [Y_W-1:0] ej_dst_y;

    logic           pe_out_valid_q, pe_out_valid_d;
    logic [P_W-1:0] pe_out_data_q, pe_out_data_d;
    logic           err_misroute_q, err_misroute_d;

    hoplite_inj_fifo #(
        .WIDTH (P_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inj_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (pe_in_valid),
        .push_data  (pe_in_data),
        .pop_req    (noc_inj_ack),
        .rd_data    (noc_inj_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Ready and valid come only from the registered FIFO flags, so an ack
    // arriving while the FIFO is full frees space only from the next cycle.
    assign pe_in_ready   = !fifo_full;
    assign noc_inj_valid = !fifo_empty;
    assign inj_pop       = noc_inj_ack && noc_inj_valid;

    // A misrouted flit is still delivered; the error flag just records that
    // one arrived.
    always_comb begin
        ej_dst_x       = noc_ej_data[DX_MSB -: X_W];
        ej_dst_y       = noc_ej_data[DY_MSB -: Y_W];
        pe_out_valid_d = noc_ej_valid;
        pe_out_data_d  = noc_ej_valid ? noc_ej_data : pe_out_data_q;
        err_misroute_d = err_misroute_q;
        if (noc_ej_valid && ((ej_dst_x != MY_X) || (ej_dst_y != MY_Y))) begin
            err_misroute_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pe_out_valid_q <= 1'b0;
            pe_out_data_q  <= '0;
            err_misroute_q <= 1'b0;
        end else begin
            pe_out_valid_q <= pe_out_valid_d;
            pe_out_data_q  <= pe_out_data_d;
            err_misroute_q <= err_misroute_d;
        end
    end

    assign pe_out_valid = pe_out_valid_q;
    assign pe_out_data  = pe_out_data_q;
    assign err_misroute = err_misroute_q;

`ifdef HOPLITE_PE_PORT_STATS_EN
    logic [31:0] stat_inj_cnt_q, stat_inj_cnt_d;
    logic [31:0] stat_ej_cnt_q, stat_ej_cnt_d;
    logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

    // Each counter sticks at all-ones rather than wrapping.
    always_comb begin
        stat_inj_cnt_d   = stat_inj_cnt_q;
        stat_ej_cnt_d    = stat_ej_cnt_q;
        stat_stall_cnt_d = stat_stall_cnt_q;
        if (inj_pop && (stat_inj_cnt_q != '1)) begin
            stat_inj_cnt_d = stat_inj_cnt_q + 32'd1;
        end
        if (noc_ej_valid && (stat_ej_cnt_q != '1)) begin
            stat_ej_cnt_d = stat_ej_cnt_q + 32'd1;
        end
        if (noc_inj_valid && !noc_inj_ack && (stat_stall_cnt_q != '1)) begin
            stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inj_cnt_q   <= '0;
            stat_ej_cnt_q    <= '0;
            stat_stall_cnt_q <= '0;
        end else begin
            stat_inj_cnt_q   <= stat_inj_cnt_d;
            stat_ej_cnt_q    <= stat_ej_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_inj_cnt   = stat_inj_cnt_q;
    assign stat_ej_cnt    = stat_ej_cnt_q;
    assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hoplite_pe_port.sv
// -----------------------------------------------------------------------------
// tb_hoplite_pe_port
//   Directed bench for hoplite_pe_port with a 4-entry FIFO at node (2,3).
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at that same point.
// -----------------------------------------------------------------------------
module tb_hoplite_pe_port;

    localparam int P_W = 32;

    logic           clk;
    logic           rst;
    logic [P_W-1:0] pe_in_data;
    logic           pe_in_valid;
    logic           pe_in_ready;
    logic [P_W-1:0] noc_inj_data;
    logic           noc_inj_valid;
    logic           noc_inj_ack;
    logic [P_W-1:0] noc_ej_data;
    logic           noc_ej_valid;
    logic [P_W-1:0] pe_out_data;
    logic           pe_out_valid;
    logic           err_misroute;
`ifdef HOPLITE_PE_PORT_STATS_EN
    logic [31:0]    stat_inj_cnt;
    logic [31:0]    stat_ej_cnt;
    logic [31:0]    stat_stall_cnt;
`endif

    int total;
    int bad;

    hoplite_pe_port #(
        .P_W        (P_W),
        .X_W        (4),
        .Y_W        (4),
        .X_ID       (2),
        .Y_ID       (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_in_data     (pe_in_data),
        .pe_in_valid    (pe_in_valid),
        .pe_in_ready    (pe_in_ready),
        .noc_inj_data   (noc_inj_data),
        .noc_inj_valid  (noc_inj_valid),
        .noc_inj_ack    (noc_inj_ack),
        .noc_ej_data    (noc_ej_data),
        .noc_ej_valid   (noc_ej_valid),
        .pe_out_data    (pe_out_data),
        .pe_out_valid   (pe_out_valid),
`ifdef HOPLITE_PE_PORT_STATS_EN
        .stat_inj_cnt   (stat_inj_cnt),
        .stat_ej_cnt    (stat_ej_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .err_misroute   (err_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [P_W-1:0] d);
        pe_in_data  = d;
        pe_in_valid = 1'b1;
        tick();
        pe_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        pe_in_data   = '0;
        pe_in_valid  = 1'b0;
        noc_inj_ack  = 1'b0;
        noc_ej_data  = '0;
        noc_ej_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (pe_in_ready !== 1'b1 || noc_inj_valid !== 1'b0 ||
                pe_out_valid !== 1'b0 || err_misroute !== 1'b0 || pe_out_data !== '0) begin
                bad++;
                $display("[TB] FAIL reset_idle cyc%0d: ready=%b inj_v=%b out_v=%b err=%b out_d=%h, need 1 0 0 0 0",
                         i, pe_in_ready, noc_inj_valid, pe_out_valid, err_misroute, pe_out_data);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [P_W-1:0] exp_d;
        noc_inj_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_flit(32'hA000_0001 + 32'(i));
            total++;
            if (noc_inj_valid !== 1'b1 || noc_inj_data !== 32'hA000_0001) begin
                bad++;
                $display("[TB] FAIL fill_head push%0d: v=%b d=%h, need 1 a0000001",
                         i, noc_inj_valid, noc_inj_data);
            end
        end
        total++;
        if (pe_in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_full_ready: got %b need 0", pe_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (noc_inj_data !== 32'hA000_0001 || noc_inj_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL head_stable cyc%0d: v=%b d=%h need 1 a0000001",
                         i, noc_inj_valid, noc_inj_data);
            end
        end
        noc_inj_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hA000_0001 + 32'(i);
            total++;
            if (noc_inj_valid !== 1'b1 || noc_inj_data !== exp_d) begin
                bad++;
                $display("[TB] FAIL drain_order %0d: v=%b d=%h need 1 %h",
                         i, noc_inj_valid, noc_inj_data, exp_d);
            end
            tick();
        end
        noc_inj_ack = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b0 || pe_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drained: v=%b ready=%b need 0 1", noc_inj_valid, pe_in_ready);
        end
    endtask

    task automatic test_full_ack_push();
        logic [P_W-1:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            push_flit(32'hA000_0001 + 32'(i));
        end
        // Full, with an ack and a new flit offered in the same cycle.
        noc_inj_ack = 1'b1;
        pe_in_valid = 1'b1;
        pe_in_data  = 32'hA000_0005;
        total++;
        if (pe_in_ready !== 1'b0 || noc_inj_data !== 32'hA000_0001) begin
            bad++;
            $display("[TB] FAIL full_ack_pre: ready=%b d=%h need 0 a0000001", pe_in_ready, noc_inj_data);
        end
        tick();
        noc_inj_ack = 1'b0;
        total++;
        if (pe_in_ready !== 1'b1 || noc_inj_data !== 32'hA000_0002) begin
            bad++;
            $display("[TB] FAIL full_ack_post: ready=%b d=%h need 1 a0000002", pe_in_ready, noc_inj_data);
        end
        tick();
        pe_in_valid = 1'b0;
        total++;
        if (pe_in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL retry_accepted: ready=%b need 0", pe_in_ready);
        end
        noc_inj_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            exp_d = 32'hA000_0001 + 32'(i);
            total++;
            if (noc_inj_valid !== 1'b1 || noc_inj_data !== exp_d) begin
                bad++;
                $display("[TB] FAIL full_ack_order %0d: v=%b d=%h need 1 %h",
                         i, noc_inj_valid, noc_inj_data, exp_d);
            end
            tick();
        end
        noc_inj_ack = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ack_empty: v=%b need 0", noc_inj_valid);
        end
    endtask

    task automatic test_spurious_ack();
        noc_inj_ack = 1'b1;
        tick();
        tick();
        noc_inj_ack = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b0 || pe_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL spurious_ack: v=%b ready=%b need 0 1", noc_inj_valid, pe_in_ready);
        end
        pe_in_data  = 32'h0000_0011;
        pe_in_valid = 1'b1;
        #1;
        total++;
        if (noc_inj_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_bypass: v=%b need 0", noc_inj_valid);
        end
        tick();
        pe_in_valid = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b1 || noc_inj_data !== 32'h0000_0011) begin
            bad++;
            $display("[TB] FAIL inj_latency: v=%b d=%h need 1 00000011", noc_inj_valid, noc_inj_data);
        end
        noc_inj_ack = 1'b1;
        tick();
        noc_inj_ack = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_pop: v=%b need 0", noc_inj_valid);
        end
    endtask

    task automatic test_ejection();
        logic [P_W-1:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            exp_d        = 32'h2300_0010 + 32'(i);
            noc_ej_data  = exp_d;
            noc_ej_valid = 1'b1;
            tick();
            total++;
            if (pe_out_valid !== 1'b1 || pe_out_data !== exp_d || err_misroute !== 1'b0) begin
                bad++;
                $display("[TB] FAIL eject %0d: v=%b d=%h err=%b need 1 %h 0",
                         i, pe_out_valid, pe_out_data, err_misroute, exp_d);
            end
        end
        noc_ej_valid = 1'b0;
        noc_ej_data  = 32'hDEAD_BEEF;
        tick();
        total++;
        if (pe_out_valid !== 1'b0 || pe_out_data !== 32'h2300_0012 || err_misroute !== 1'b0) begin
            bad++;
            $display("[TB] FAIL eject_hold: v=%b d=%h err=%b need 0 23000012 0",
                     pe_out_valid, pe_out_data, err_misroute);
        end
    endtask

    task automatic test_misroute();
`ifdef HOPLITE_PE_PORT_STATS_EN
        logic [31:0] ej_before;
        ej_before = stat_ej_cnt;
`endif
        noc_ej_data  = 32'h4500_0000;
        noc_ej_valid = 1'b1;
        tick();
        noc_ej_valid = 1'b0;
        total++;
        if (pe_out_valid !== 1'b1 || pe_out_data !== 32'h4500_0000 || err_misroute !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misroute: v=%b d=%h err=%b need 1 45000000 1",
                     pe_out_valid, pe_out_data, err_misroute);
        end
`ifdef HOPLITE_PE_PORT_STATS_EN
        total++;
        if (stat_ej_cnt !== ej_before + 32'd1) begin
            bad++;
            $display("[TB] FAIL stat_ej: got %0d need %0d", stat_ej_cnt, ej_before + 32'd1);
        end
`endif
        tick();
        tick();
        total++;
        if (err_misroute !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misroute_sticky: got %b need 1", err_misroute);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (err_misroute !== 1'b0 || pe_out_data !== '0) begin
            bad++;
            $display("[TB] FAIL misroute_clear: err=%b d=%h need 0 0", err_misroute, pe_out_data);
        end
        // Only the Y field is wrong here: x=2 matches, y=4 does not.
        noc_ej_data  = 32'h2400_0000;
        noc_ej_valid = 1'b1;
        tick();
        noc_ej_valid = 1'b0;
        total++;
        if (err_misroute !== 1'b1 || pe_out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misroute_y: err=%b v=%b need 1 1", err_misroute, pe_out_valid);
        end
    endtask

    task automatic test_reset_mid();
        push_flit(32'hB000_0001);
        push_flit(32'hB000_0002);
        rst          = 1'b1;
        noc_ej_data  = 32'h2300_0099;
        noc_ej_valid = 1'b1;
        pe_in_data   = 32'hB000_0003;
        pe_in_valid  = 1'b1;
        tick();
        rst          = 1'b0;
        noc_ej_valid = 1'b0;
        pe_in_valid  = 1'b0;
        total++;
        if (noc_inj_valid !== 1'b0 || pe_out_valid !== 1'b0 || pe_in_ready !== 1'b1 ||
            err_misroute !== 1'b0 || pe_out_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid: inj_v=%b out_v=%b ready=%b err=%b d=%h need 0 0 1 0 0",
                     noc_inj_valid, pe_out_valid, pe_in_ready, err_misroute, pe_out_data);
        end
        tick();
        total++;
        if (noc_inj_valid !== 1'b0 || pe_out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_after: inj_v=%b out_v=%b need 0 0", noc_inj_valid, pe_out_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill_drain();
        test_full_ack_push();
        test_spurious_ack();
        test_ejection();
        test_misroute();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
